// File: rtl/top_axi_pkg.sv
// Shared constants, streamer state type and saturation bounds for top_axi_interface.
package top_axi_pkg;

  localparam int DEF_SIZE   = 32;
  localparam int DEF_I_BITS = 8;
  localparam int DEF_O_BITS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } strm_state_e;

  // Signed O-bit range limits, widened so any lane sum can be compared directly.
  function automatic logic signed [63:0] sat_max(input int ob);
    return (64'sd1 <<< (ob - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int ob);
    return -(64'sd1 <<< (ob - 1));
  endfunction

  localparam logic signed [63:0] DEF_SAT_MAX = sat_max(DEF_O_BITS);
  localparam logic signed [63:0] DEF_SAT_MIN = sat_min(DEF_O_BITS);

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane. Define ACC_SATURATE_EN to clamp the
// accumulator to the signed O_BITS range; otherwise it wraps two's complement.
module mac_lane
  import top_axi_pkg::*;
#(
  parameter int I_BITS = DEF_I_BITS,
  parameter int O_BITS = DEF_O_BITS
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic                     i_active,
  input  logic                     i_clear,
  input  logic signed [I_BITS-1:0] i_a,
  input  logic signed [I_BITS-1:0] i_b,
  output logic signed [O_BITS-1:0] o_sum
);

  localparam int SW = ((O_BITS > 2 * I_BITS) ? O_BITS : 2 * I_BITS) + 1;

  logic signed [O_BITS-1:0]   acc;
  logic signed [2*I_BITS-1:0] prod;
  logic signed [SW-1:0]       sum_w;
  logic signed [O_BITS-1:0]   sum;

  assign prod  = (2 * I_BITS)'(i_a) * (2 * I_BITS)'(i_b);
  assign sum_w = SW'(acc) + SW'(prod);

`ifdef ACC_SATURATE_EN
  logic signed [63:0] sum_x;
  assign sum_x = 64'(sum_w);

  always_comb begin
    if (sum_x > sat_max(O_BITS))      sum = O_BITS'(sat_max(O_BITS));
    else if (sum_x < sat_min(O_BITS)) sum = O_BITS'(sat_min(O_BITS));
    else                              sum = O_BITS'(sum_w);
  end
`else
  assign sum = O_BITS'(sum_w);
`endif

  // Inactive lanes report 0 so the latched diagonal is clean beyond N.
  assign o_sum = i_active ? sum : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset)      acc <= '0;
    else if (i_valid) acc <= (i_clear || !i_active) ? '0 : sum;
  end

endmodule

// File: rtl/top_axi_interface.sv
// Diagonal MAC array with AXI-Stream result streamer. Build option:
// ACC_SATURATE_EN selects saturating accumulation in every mac_lane.
module top_axi_interface
  import top_axi_pkg::*;
#(
  parameter int SIZE                   = DEF_SIZE,
  parameter int I_BITS                 = DEF_I_BITS,
  parameter int O_BITS                 = DEF_O_BITS,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_valid,
  input  logic [I_BITS*SIZE-1:0]                i_a_full,
  input  logic [I_BITS*SIZE-1:0]                i_b_full,
  input  logic [2:0]                            rf_matrix_size,
  output logic [SIZE*O_BITS-1:0]                o_c_diag_to_buffer,
  output logic                                  o_overflow,
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready
);

  localparam int IW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int TDW = C_M00_AXIS_TDATA_WIDTH;

  logic [IW-1:0]                  cnt, n_m1_q, n_m1_rf, n_m1_cur;
  logic                           frame_done;
  logic [SIZE-1:0]                lane_act;
  logic [SIZE-1:0][O_BITS-1:0]    lane_sum, diag_q, snap_q;

  logic unused_axis;
  assign unused_axis = m00_axis_aclk ^ m00_axis_aresetn;

  // Requested dimension, clamped to the lane count, held as N-1.
  always_comb begin
    int n;
    n = 1 << rf_matrix_size;
    if (n > SIZE) n = SIZE;
    n_m1_rf = IW'(n - 1);
  end

  // The size input only matters on beat 0; later beats use the frame's copy.
  assign n_m1_cur   = (cnt == '0) ? n_m1_rf : n_m1_q;
  assign frame_done = i_valid && (cnt == n_m1_cur);

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    assign lane_act[k] = (IW'(k) <= n_m1_cur);

    mac_lane #(
      .I_BITS (I_BITS),
      .O_BITS (O_BITS)
    ) u_lane (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_valid  (i_valid),
      .i_active (lane_act[k]),
      .i_clear  (frame_done),
      .i_a      (i_a_full[I_BITS*k +: I_BITS]),
      .i_b      (i_b_full[I_BITS*k +: I_BITS]),
      .o_sum    (lane_sum[k])
    );
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt    <= '0;
      n_m1_q <= '0;
      diag_q <= '0;
    end else begin
      if (i_valid) begin
        if (cnt == '0) n_m1_q <= n_m1_rf;
        cnt <= frame_done ? '0 : cnt + 1'b1;
      end
      if (frame_done) diag_q <= lane_sum;
    end
  end

  assign o_c_diag_to_buffer = diag_q;

  // ---------------------------------------------------------------- streamer
  strm_state_e   state, state_nx;
  logic [IW-1:0] beat, beat_nx, snap_n_m1;
  logic          load, ovf_set, last_beat, hs;

  assign last_beat = (beat == snap_n_m1);
  assign hs        = (state == SEND) && m00_axis_tready;

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    load     = 1'b0;
    ovf_set  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_done) begin
          state_nx = SEND;
          load     = 1'b1;
        end
      end
      SEND: begin
        // A frame landing on the tlast handshake chains straight into a new stream.
        if (hs && last_beat) begin
          if (frame_done) load = 1'b1;
          else            state_nx = IDLE;
        end else begin
          if (hs)         beat_nx = beat + 1'b1;
          if (frame_done) ovf_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) beat_nx = '0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
    end
  end

  // Private snapshot so an overflowing frame cannot disturb the stream in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      snap_q     <= '0;
      snap_n_m1  <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (load) begin
        snap_q    <= lane_sum;
        snap_n_m1 <= n_m1_cur;
      end
      if (ovf_set) o_overflow <= 1'b1;
    end
  end

  logic signed [O_BITS-1:0] cur_lane;
  assign cur_lane = snap_q[beat];

  assign m00_axis_tvalid = (state == SEND);
  assign m00_axis_tlast  = (state == SEND) && last_beat;
  assign m00_axis_tdata  = (state == SEND) ? TDW'(cur_lane) : '0;
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_top_axi_interface.sv
// Directed and randomized bench for top_axi_interface against a dot-product model.
module tb_top_axi_interface;

  localparam int SIZE   = 32;
  localparam int I_BITS = 8;
  localparam int O_BITS = 16;
  localparam int TDW    = 32;

  logic                     i_clock = 1'b0;
  logic                     i_reset;
  logic                     i_valid;
  logic [I_BITS*SIZE-1:0]   i_a_full, i_b_full;
  logic [2:0]               rf;
  logic [SIZE*O_BITS-1:0]   diag;
  logic                     ovf;
  logic                     aresetn;
  logic                     tvalid, tlast, tready;
  logic [TDW-1:0]           tdata;
  logic [TDW/8-1:0]         tstrb;

  always #5 i_clock = ~i_clock;

  top_axi_interface #(
    .SIZE (SIZE), .I_BITS (I_BITS), .O_BITS (O_BITS), .C_M00_AXIS_TDATA_WIDTH (TDW)
  ) dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_valid            (i_valid),
    .i_a_full           (i_a_full),
    .i_b_full           (i_b_full),
    .rf_matrix_size     (rf),
    .o_c_diag_to_buffer (diag),
    .o_overflow         (ovf),
    .m00_axis_aclk      (i_clock),
    .m00_axis_aresetn   (aresetn),
    .m00_axis_tvalid    (tvalid),
    .m00_axis_tdata     (tdata),
    .m00_axis_tstrb     (tstrb),
    .m00_axis_tlast     (tlast),
    .m00_axis_tready    (tready)
  );

  int checks = 0;
  int errors = 0;
  int exp_diag[SIZE];
  logic [TDW:0] exp_q[$], rcv_q[$], last_q[$];
  bit           stall_prev = 1'b0;
  logic [TDW:0] stall_val;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int acc_step(input int acc, input int p);
    int s;
    s = acc + p;
`ifdef ACC_SATURATE_EN
    if (s > (1 << (O_BITS - 1)) - 1) s = (1 << (O_BITS - 1)) - 1;
    if (s < -(1 << (O_BITS - 1)))    s = -(1 << (O_BITS - 1));
`else
    s = s & ((1 << O_BITS) - 1);
    if (s >= (1 << (O_BITS - 1))) s = s - (1 << O_BITS);
`endif
    return s;
  endfunction

  // One cycle: inputs applied at negedge, outputs sampled before the posedge.
  task automatic tick(input bit v, input bit rdy);
    i_valid = v;
    tready  = rdy;
    #1;
    if (stall_prev) chk("stall_hold", {tlast, tdata}, stall_val);
    stall_prev = tvalid && !rdy;
    stall_val  = {tlast, tdata};
    if (tvalid && rdy) rcv_q.push_back({tlast, tdata});
    @(negedge i_clock);
  endtask

  task automatic reset_dut();
    i_reset = 1'b1;
    tick(0, 0);
    i_reset = 1'b0;
    stall_prev = 1'b0;
    rcv_q.delete();
    exp_q.delete();
  endtask

  // mode: 0 random, 1 a=1 b=k+1, 2 a=b=127, 3 a=-2 b=3
  task automatic feed_frame(input int rf_v, input int mode, input bit rdy, input bit gaps);
    int n, acc;
    int av[SIZE][SIZE];
    int bv[SIZE][SIZE];
    n = 1 << rf_v;
    if (n > SIZE) n = SIZE;
    for (int b = 0; b < n; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 2) == 0) begin
        i_a_full = {(SIZE * I_BITS / 32){$urandom()}};
        i_b_full = {(SIZE * I_BITS / 32){$urandom()}};
        rf = 3'($urandom_range(0, 7));
        tick(0, rdy);
      end
      for (int k = 0; k < SIZE; k++) begin
        case (mode)
          1:       begin av[b][k] = 1;   bv[b][k] = k + 1; end
          2:       begin av[b][k] = 127; bv[b][k] = 127;   end
          3:       begin av[b][k] = -2;  bv[b][k] = 3;     end
          default: begin
            av[b][k] = int'($urandom_range(0, 255)) - 128;
            bv[b][k] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
        i_a_full[I_BITS*k +: I_BITS] = I_BITS'(av[b][k]);
        i_b_full[I_BITS*k +: I_BITS] = I_BITS'(bv[b][k]);
      end
      rf = (b == 0) ? 3'(rf_v) : 3'($urandom_range(0, 7));
      tick(1, rdy);
    end
    last_q.delete();
    for (int k = 0; k < SIZE; k++) begin
      exp_diag[k] = 0;
      if (k < n) begin
        acc = 0;
        for (int b = 0; b < n; b++) acc = acc_step(acc, av[b][k] * bv[b][k]);
        exp_diag[k] = acc;
        last_q.push_back({(k == n - 1), TDW'(acc)});
      end
    end
  endtask

  task automatic check_diag(input string tag);
    logic [SIZE*O_BITS-1:0] e;
    for (int k = 0; k < SIZE; k++) e[O_BITS*k +: O_BITS] = O_BITS'(exp_diag[k]);
    chk(tag, diag, e);
  endtask

  task automatic push_expected();
    foreach (last_q[i]) exp_q.push_back(last_q[i]);
  endtask

  task automatic drain(input string tag, input bit rnd);
    int budget, m;
    budget = 400;
    while (rcv_q.size() < exp_q.size() && budget > 0) begin
      tick(0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    chk({tag, "_count"}, rcv_q.size(), exp_q.size());
    m = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_beat"}, rcv_q[i], exp_q[i]);
    chk({tag, "_idle"}, tvalid, 1'b0);
    rcv_q.delete();
    exp_q.delete();
  endtask

  initial begin
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_a_full = '0;
    i_b_full = '0;
    rf       = 3'd0;
    tready   = 1'b0;
    aresetn  = 1'b1;
    @(negedge i_clock);
    reset_dut();
    chk("rst_diag",   diag,   '0);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast",  tlast,  1'b0);
    chk("rst_tdata",  tdata,  '0);
    chk("rst_ovf",    ovf,    1'b0);
    chk("tstrb_ones", tstrb,  4'hF);

    // N=4, a=1, b=k+1
    feed_frame(2, 1, 0, 0);
    check_diag("ramp_diag");
    chk("ramp_lane0", diag[15:0],  16'd4);
    chk("ramp_lane3", diag[63:48], 16'd16);
    chk("ramp_lane4", diag[79:64], 16'd0);
    chk("ramp_tvalid", tvalid, 1'b1);
    push_expected();
    drain("ramp", 0);

    // back-pressure for 3 cycles mid-stream
    feed_frame(2, 0, 0, 0);
    check_diag("stall_diag");
    push_expected();
    tick(0, 1);
    tick(0, 0); tick(0, 0); tick(0, 0);
    drain("stall", 0);

    // 127*127 accumulated 4 times
    feed_frame(2, 2, 0, 0);
`ifdef ACC_SATURATE_EN
    chk("big_lane0", diag[15:0], 16'h7FFF);
`else
    chk("big_lane0", diag[15:0], 16'hFC04);
`endif
    check_diag("big_diag");
    push_expected();
    drain("big", 0);

    // negative results, sign extension onto tdata
    feed_frame(2, 3, 0, 0);
    chk("neg_lane0", diag[15:0], 16'hFFE8);
    chk("neg_tdata", tdata, 32'hFFFFFFE8);
    chk("neg_tlast", tlast, 1'b0);
    push_expected();
    drain("neg", 0);

    // next frame completes on the tlast handshake cycle
    feed_frame(2, 0, 0, 0);
    push_expected();
    feed_frame(2, 0, 1, 0);
    push_expected();
    check_diag("chain_diag");
    chk("chain_ovf", ovf, 1'b0);
    chk("chain_tvalid", tvalid, 1'b1);
    drain("chain", 0);

    // frame completes while the previous is stuck
    feed_frame(2, 0, 0, 0);
    push_expected();
    feed_frame(2, 0, 0, 0);
    check_diag("ovf_diag");
    chk("ovf_set", ovf, 1'b1);
    drain("ovf", 1);
    chk("ovf_sticky", ovf, 1'b1);

    // reset in the middle of a stream
    feed_frame(2, 0, 0, 0);
    tick(0, 1);
    tick(0, 1);
    reset_dut();
    chk("rstm_tvalid", tvalid, 1'b0);
    chk("rstm_tdata",  tdata,  '0);
    chk("rstm_ovf",    ovf,    1'b0);
    chk("rstm_diag",   diag,   '0);
    tick(0, 1); tick(0, 1); tick(0, 1);
    chk("rstm_quiet", rcv_q.size(), 0);

    // reset after 2 beats of a frame, then a clean frame
    rf = 3'd2;
    i_a_full = {(SIZE * I_BITS / 32){$urandom()}};
    i_b_full = {(SIZE * I_BITS / 32){$urandom()}};
    tick(1, 0);
    tick(1, 0);
    reset_dut();
    chk("rstf_diag",   diag,   '0);
    chk("rstf_tvalid", tvalid, 1'b0);
    feed_frame(2, 0, 0, 0);
    check_diag("rstf_clean");
    push_expected();
    drain("rstf", 0);

    // random sizes, idle gaps and random back-pressure
    for (int f = 0; f < 12; f++) begin
      feed_frame($urandom_range(0, 7), 0, 0, 1);
      check_diag("rand_diag");
      push_expected();
      drain("rand", 1);
    end
    chk("rand_ovf", ovf, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
